// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game controller.
// The state enum, the status and hint encodings, and the default parameters
// all live here.
package game_pkg;

  localparam int DEF_NUM_LEVELS     = 10;
  localparam int DEF_MAX_TRIES      = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [2:0] {
    S_PLAY,
    S_WRONG,
    S_CORRECT,
    S_LOCKED,
    S_DONE
  } state_e;

  localparam logic [2:0] STATUS_PLAY    = 3'b000;
  localparam logic [2:0] STATUS_CORRECT = 3'b010;
  localparam logic [2:0] STATUS_WRONG   = 3'b001;
  localparam logic [2:0] STATUS_LOCKED  = 3'b100;
  localparam logic [2:0] STATUS_DONE    = 3'b111;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;

  // One-to-one mapping from FSM state to the externally visible status code.
  function automatic logic [2:0] status_of(input state_e s);
    logic [2:0] code;
    code = STATUS_PLAY;
    case (s)
      S_PLAY:    code = STATUS_PLAY;
      S_WRONG:   code = STATUS_WRONG;
      S_CORRECT: code = STATUS_CORRECT;
      S_LOCKED:  code = STATUS_LOCKED;
      S_DONE:    code = STATUS_DONE;
      default:   code = STATUS_PLAY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/game_ctrl_idle_timer.sv
// Idle-cycle counter for game_ctrl.
// Counts while enable is high.  clear has priority over counting.
// expired is high in the cycle the count sits at TIMEOUT_CYCLES-1 while
// enabled, so the owner can act on that same edge.
module idle_timer
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter register: clear wins, otherwise advance while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: level/score/tries controller for a guess-the-answer game.
// Optional feature macro: GAME_CTRL_HINT_EN adds the registered hint output.
//
// The answer for the current level comes from an external combinational
// memory addressed by rom_addr (= current level).  status is a registered
// one-to-one decode of the FSM state and is the observable view of that FSM.
//
// Input pulses: submit_p and next_p are single-cycle, already debounced.
// They are acted on in the cycle they are high; the outcome is visible after
// the next rising edge.  submit_p outranks next_p while a guess can still be
// evaluated (PLAY/WRONG); next_p outranks an idle timeout in the same cycle.
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS     = DEF_NUM_LEVELS,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       submit_p,
  input  logic       next_p,
  input  logic [3:0] guess,
  output logic [3:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [2:0] status,
  output logic [3:0] score,
  output logic [1:0] tries_left
`ifdef GAME_CTRL_HINT_EN
  ,
  output logic [1:0] hint
`endif
);

  localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [1:0] FULL_TRIES = 2'(MAX_TRIES);

  state_e     state, state_n;
  logic [3:0] level, level_n;
  logic [3:0] score_n;
  logic [1:0] tries_n;
  logic       in_play;
  logic       match;
  logic       expired;
  logic       timer_clear;
`ifdef GAME_CTRL_HINT_EN
  logic [1:0] hint_n;
`endif

  assign in_play  = (state == S_PLAY) || (state == S_WRONG);
  assign match    = (guess == rom_data);
  assign rom_addr = level;

  // The counter only runs while a guess is pending; any player action, a
  // timeout, or sitting in a non-playing state restarts it from zero.
  assign timer_clear = !in_play || submit_p || next_p || expired;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (in_play),
    .expired(expired)
  );

  // State, level, score, tries, status (and hint) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_PLAY;
      level      <= '0;
      score      <= '0;
      tries_left <= FULL_TRIES;
      status     <= STATUS_PLAY;
`ifdef GAME_CTRL_HINT_EN
      hint       <= HINT_NONE;
`endif
    end else begin
      state      <= state_n;
      level      <= level_n;
      score      <= score_n;
      tries_left <= tries_n;
      status     <= status_of(state_n);
`ifdef GAME_CTRL_HINT_EN
      hint       <= hint_n;
`endif
    end
  end

  // Next-state logic: evaluate guesses, timeouts, advances and restarts.
  always_comb begin
    state_n = state;
    level_n = level;
    score_n = score;
    tries_n = tries_left;
`ifdef GAME_CTRL_HINT_EN
    hint_n  = hint;
`endif
    case (state)
      S_PLAY, S_WRONG: begin
        if (submit_p) begin
          if (match) begin
            state_n = S_CORRECT;
            if (score != 4'hF) begin
              score_n = score + 4'd1;
            end
`ifdef GAME_CTRL_HINT_EN
            hint_n = HINT_NONE;
`endif
          end else begin
            tries_n = tries_left - 2'd1;
            state_n = (tries_left == 2'd1) ? S_LOCKED : S_WRONG;
`ifdef GAME_CTRL_HINT_EN
            hint_n = (guess < rom_data) ? HINT_LOW : HINT_HIGH;
`endif
          end
        end else if (next_p) begin
          // Skip: score is left alone.
          if (level != LAST_LEVEL) begin
            level_n = level + 4'd1;
            tries_n = FULL_TRIES;
            state_n = S_PLAY;
          end else begin
            state_n = S_DONE;
          end
`ifdef GAME_CTRL_HINT_EN
          hint_n = HINT_NONE;
`endif
        end else if (expired) begin
          // Timeout counts as a wrong attempt without a direction.
          tries_n = tries_left - 2'd1;
          state_n = (tries_left == 2'd1) ? S_LOCKED : S_WRONG;
`ifdef GAME_CTRL_HINT_EN
          hint_n = HINT_NONE;
`endif
        end
      end
      S_CORRECT, S_LOCKED: begin
        if (next_p) begin
          if (level != LAST_LEVEL) begin
            level_n = level + 4'd1;
            tries_n = FULL_TRIES;
            state_n = S_PLAY;
          end else begin
            state_n = S_DONE;
          end
`ifdef GAME_CTRL_HINT_EN
          hint_n = HINT_NONE;
`endif
        end
      end
      S_DONE: begin
        if (next_p) begin
          level_n = '0;
          score_n = '0;
          tries_n = FULL_TRIES;
          state_n = S_PLAY;
`ifdef GAME_CTRL_HINT_EN
          hint_n = HINT_NONE;
`endif
        end
      end
      default: begin
        state_n = S_PLAY;
      end
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Testbench for game_ctrl: directed scenarios plus randomized play checked
// against a rule-level reference model.  Honours GAME_CTRL_HINT_EN.
module tb_game_ctrl;

  localparam int NUM_LEVELS = 10;
  localparam int MAX_TRIES  = 3;
  localparam int TIMEOUT    = 20;

  localparam logic [2:0] ST_PLAY    = 3'b000;
  localparam logic [2:0] ST_CORRECT = 3'b010;
  localparam logic [2:0] ST_WRONG   = 3'b001;
  localparam logic [2:0] ST_LOCKED  = 3'b100;
  localparam logic [2:0] ST_DONE    = 3'b111;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       submit_p = 1'b0;
  logic       next_p = 1'b0;
  logic [3:0] guess = 4'd0;
  logic [3:0] rom_addr;
  logic [3:0] rom_data;
  logic [2:0] status;
  logic [3:0] score;
  logic [1:0] tries_left;
`ifdef GAME_CTRL_HINT_EN
  logic [1:0] dut_hint;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [3:0] answer(input int lvl);
    return 4'((13 * lvl + 46) % 16);
  endfunction

  assign rom_data = answer(int'(rom_addr));

  game_ctrl #(
    .NUM_LEVELS(NUM_LEVELS),
    .MAX_TRIES(MAX_TRIES),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .submit_p(submit_p),
    .next_p(next_p),
    .guess(guess),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .status(status),
    .score(score),
    .tries_left(tries_left)
`ifdef GAME_CTRL_HINT_EN
    ,
    .hint(dut_hint)
`endif
  );

  // ---------------- reference model ----------------
  int         m_level, m_score, m_tries, m_idle;
  logic [2:0] m_status;
  logic [1:0] m_hint;

  task automatic model_reset();
    m_level = 0; m_score = 0; m_tries = MAX_TRIES; m_idle = 0;
    m_status = ST_PLAY; m_hint = 2'b00;
  endtask

  task automatic model_miss();
    m_tries = m_tries - 1;
    m_status = (m_tries == 0) ? ST_LOCKED : ST_WRONG;
  endtask

  // One clock of game rules applied to the model.
  task automatic model_step(input logic sub, input logic nxt, input logic [3:0] g);
    logic [3:0] ans;
    bit playing, acted;
    ans = answer(m_level);
    playing = (m_status == ST_PLAY) || (m_status == ST_WRONG);
    acted = 1'b0;
    if (playing && sub) begin
      acted = 1'b1;
      if (g == ans) begin
        m_status = ST_CORRECT;
        if (m_score < 15) m_score = m_score + 1;
        m_hint = 2'b00;
      end else begin
        model_miss();
        m_hint = (g < ans) ? 2'b01 : 2'b10;
      end
    end else if (nxt && m_status != ST_DONE) begin
      acted = 1'b1;
      if (m_level < NUM_LEVELS - 1) begin
        m_level = m_level + 1; m_tries = MAX_TRIES; m_status = ST_PLAY;
      end else begin
        m_status = ST_DONE;
      end
      m_hint = 2'b00;
    end else if (nxt) begin
      acted = 1'b1;
      m_level = 0; m_score = 0; m_tries = MAX_TRIES; m_status = ST_PLAY;
      m_hint = 2'b00;
    end else if (playing && m_idle == TIMEOUT - 1) begin
      acted = 1'b1;
      model_miss();
      m_hint = 2'b00;
    end
    if (acted || !playing) m_idle = 0;
    else m_idle = m_idle + 1;
  endtask

  // ---------------- driver ----------------
  // Drive inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic step(input logic sub, input logic nxt, input logic [3:0] g);
    submit_p = sub; next_p = nxt; guess = g;
    @(posedge clk);
    model_step(sub, nxt, g);
    #1;
    submit_p = 1'b0; next_p = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_tests++; if (status !== ST_PLAY) begin n_fail++; $display("FAIL reset_status: got %b expected %b", status, ST_PLAY); end
    n_tests++; if (score !== 4'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_tests++; if (tries_left !== 2'd3) begin n_fail++; $display("FAIL reset_tries: got %0d expected 3", tries_left); end
    n_tests++; if (rom_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
`ifdef GAME_CTRL_HINT_EN
    n_tests++; if (dut_hint !== 2'b00) begin n_fail++; $display("FAIL reset_hint: got %b expected 00", dut_hint); end
`endif
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_solve();
    step(1'b1, 1'b0, 4'd14);
    n_tests++; if (status !== ST_CORRECT) begin n_fail++; $display("FAIL solve_status: got %b expected 010", status); end
    n_tests++; if (score !== 4'd1) begin n_fail++; $display("FAIL solve_score: got %0d expected 1", score); end
    step(1'b0, 1'b1, 4'd0);
    n_tests++; if (rom_addr !== 4'd1) begin n_fail++; $display("FAIL advance_level: got %0d expected 1", rom_addr); end
    n_tests++; if (status !== ST_PLAY) begin n_fail++; $display("FAIL advance_status: got %b expected 000", status); end
    n_tests++; if (tries_left !== 2'd3) begin n_fail++; $display("FAIL advance_tries: got %0d expected 3", tries_left); end
  endtask

  task automatic test_lockout();
    logic [3:0] gs [3];
    logic [2:0] exp_st [3];
    gs = '{4'd3, 4'd4, 4'd5};
    exp_st = '{ST_WRONG, ST_WRONG, ST_LOCKED};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, gs[i]);
      n_tests++; if (status !== exp_st[i]) begin n_fail++; $display("FAIL lock_status[%0d]: got %b expected %b", i, status, exp_st[i]); end
      n_tests++; if (tries_left !== 2'(2 - i)) begin n_fail++; $display("FAIL lock_tries[%0d]: got %0d expected %0d", i, tries_left, 2 - i); end
`ifdef GAME_CTRL_HINT_EN
      n_tests++; if (dut_hint !== 2'b01) begin n_fail++; $display("FAIL lock_hint[%0d]: got %b expected 01", i, dut_hint); end
`endif
    end
    step(1'b1, 1'b0, 4'd11);
    n_tests++; if (status !== ST_LOCKED) begin n_fail++; $display("FAIL locked_ignore_status: got %b expected 100", status); end
    n_tests++; if (tries_left !== 2'd0) begin n_fail++; $display("FAIL locked_ignore_tries: got %0d expected 0", tries_left); end
    n_tests++; if (score !== 4'd1) begin n_fail++; $display("FAIL locked_ignore_score: got %0d expected 1", score); end
  endtask

  task automatic test_done();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd0);
    n_tests++; if (rom_addr !== 4'd9) begin n_fail++; $display("FAIL skip_to_9: got %0d expected 9", rom_addr); end
    n_tests++; if (score !== 4'd1) begin n_fail++; $display("FAIL skip_score: got %0d expected 1", score); end
    step(1'b1, 1'b0, 4'd3);
    n_tests++; if (status !== ST_CORRECT) begin n_fail++; $display("FAIL last_solve: got %b expected 010", status); end
    step(1'b0, 1'b1, 4'd0);
    n_tests++; if (status !== ST_DONE) begin n_fail++; $display("FAIL done_status: got %b expected 111", status); end
    n_tests++; if (rom_addr !== 4'd9) begin n_fail++; $display("FAIL done_level: got %0d expected 9", rom_addr); end
    step(1'b1, 1'b0, 4'd3);
    n_tests++; if (status !== ST_DONE || score !== 4'd2) begin n_fail++; $display("FAIL done_ignore_submit: got %b/%0d expected 111/2", status, score); end
    step(1'b0, 1'b1, 4'd0);
    n_tests++; if (rom_addr !== 4'd0 || score !== 4'd0 || status !== ST_PLAY || tries_left !== 2'd3) begin
      n_fail++; $display("FAIL restart: got lvl %0d sc %0d st %b tr %0d expected 0 0 000 3", rom_addr, score, status, tries_left);
    end
  endtask

  task automatic test_timeout();
    idle(TIMEOUT - 1);
    n_tests++; if (tries_left !== 2'd3 || status !== ST_PLAY) begin n_fail++; $display("FAIL timeout_early: got tr %0d st %b expected 3 000", tries_left, status); end
    idle(1);
    n_tests++; if (tries_left !== 2'd2 || status !== ST_WRONG) begin n_fail++; $display("FAIL timeout_fire: got tr %0d st %b expected 2 001", tries_left, status); end
    step(1'b1, 1'b1, 4'd14);
    n_tests++; if (status !== ST_CORRECT || rom_addr !== 4'd0 || score !== 4'd1) begin
      n_fail++; $display("FAIL submit_over_next: got st %b lvl %0d sc %0d expected 010 0 1", status, rom_addr, score);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 4'd3);
    idle(10);
    reset = 1'b1;
    #2;
    n_tests++; if (status !== ST_PLAY || score !== 4'd0 || tries_left !== 2'd3 || rom_addr !== 4'd0) begin
      n_fail++; $display("FAIL async_reset: got st %b sc %0d tr %0d lvl %0d expected 000 0 3 0", status, score, tries_left, rom_addr);
    end
`ifdef GAME_CTRL_HINT_EN
    n_tests++; if (dut_hint !== 2'b00) begin n_fail++; $display("FAIL async_reset_hint: got %b expected 00", dut_hint); end
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(TIMEOUT - 1);
    n_tests++; if (tries_left !== 2'd3) begin n_fail++; $display("FAIL reset_idle_cleared: got %0d expected 3", tries_left); end
    idle(1);
    n_tests++; if (tries_left !== 2'd2) begin n_fail++; $display("FAIL reset_idle_timeout: got %0d expected 2", tries_left); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd1);
    n_tests++; if (status !== ST_WRONG || tries_left !== 2'd1) begin n_fail++; $display("FAIL b2b_wrong: got %b/%0d expected 001/1", status, tries_left); end
    step(1'b1, 1'b0, 4'd14);
    n_tests++; if (status !== ST_CORRECT || score !== 4'd1 || tries_left !== 2'd1) begin
      n_fail++; $display("FAIL b2b_correct: got %b/%0d/%0d expected 010/1/1", status, score, tries_left);
    end
  endtask

`ifdef GAME_CTRL_HINT_EN
  task automatic test_hint();
    do_reset();
    step(1'b1, 1'b0, 4'd2);
    n_tests++; if (dut_hint !== 2'b01) begin n_fail++; $display("FAIL hint_low: got %b expected 01", dut_hint); end
    step(1'b1, 1'b0, 4'd15);
    n_tests++; if (dut_hint !== 2'b10) begin n_fail++; $display("FAIL hint_high: got %b expected 10", dut_hint); end
    step(1'b1, 1'b0, 4'd14);
    n_tests++; if (dut_hint !== 2'b00) begin n_fail++; $display("FAIL hint_match: got %b expected 00", dut_hint); end
  endtask
`endif

  task automatic test_random();
    bit quiet;
    logic s, n;
    logic [3:0] g;
    do_reset();
    for (int c = 0; c < 3000 && n_fail < 20; c++) begin
      quiet = ((c / 150) % 2) == 1;
      s = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
      n = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 7) == 0);
      g = ($urandom_range(0, 2) == 0) ? answer(m_level) : 4'($urandom_range(0, 15));
      step(s, n, g);
      n_tests++; if (status !== m_status) begin n_fail++; $display("FAIL rnd_status c%0d: got %b expected %b", c, status, m_status); end
      n_tests++; if (score !== 4'(m_score)) begin n_fail++; $display("FAIL rnd_score c%0d: got %0d expected %0d", c, score, m_score); end
      n_tests++; if (tries_left !== 2'(m_tries)) begin n_fail++; $display("FAIL rnd_tries c%0d: got %0d expected %0d", c, tries_left, m_tries); end
      n_tests++; if (rom_addr !== 4'(m_level)) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d expected %0d", c, rom_addr, m_level); end
`ifdef GAME_CTRL_HINT_EN
      n_tests++; if (dut_hint !== m_hint) begin n_fail++; $display("FAIL rnd_hint c%0d: got %b expected %b", c, dut_hint, m_hint); end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_solve();
    test_lockout();
    test_done();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef GAME_CTRL_HINT_EN
    test_hint();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
